cfg_loader: RTL and testbench

- Bitstream loader that sits directly upstream of the connection box configuration chains.
- Accepts parallel configuration words over a valid/ready handshake and serialises them onto two chains, A and B, in lockstep.
- Drives the shared chain shift enable so that exactly CHAIN_LEN bits land in each chain, MSB-first, matching the chains' shift-on-rising-edge behaviour.

---
 rtl/cfg_loader.sv | 211 +++++++++++++++++++++
 tb/tb_cfg_loader.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_loader.sv
`default_nettype none
// ============================================================================
//  Module   : cfg_loader
//  Purpose  : Configuration bitstream loader for the connection box chains.
//             Takes parallel words over a valid/ready handshake and shifts
//             them, two bits per cycle, onto chains A and B in lockstep.
//             It drives the shared chain shift enable so that exactly
//             CHAIN_LEN bits land in each chain, MSB-first.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Optional feature macro: CFG_LOADER_CRC_EN
//    When this macro is defined, a running CRC-8 (poly 0x07, init 0x00,
//    MSB-first) is kept over every accepted data word. After the final shift
//    the loader accepts one extra word, compares its low byte with the CRC
//    and flags crc_err on a mismatch. When it is undefined, there is no
//    CHECK state and crc_err is tied low.
// ----------------------------------------------------------------------------
//  Parameters
//    WORD_W     input word width (even, >= 8)
//    CHAIN_LEN  bits loaded into each chain per load
//  Ports
//    clk            fabric / configuration clock
//    nrst           asynchronous active-low reset
//    en             global enable; low freezes every piece of state
//    start          single-cycle pulse that begins a load (IDLE/DONE only)
//    in_data        configuration word
//    in_valid       in_data is valid
//    in_ready       loader accepts a word this cycle
//    cfg_data_outA  serial bit to chain A
//    cfg_data_outB  serial bit to chain B
//    cfg_en         chain shift enable
//    busy           load in progress (LOAD / SHIFT / CHECK)
//    done           load completed; held until the next start
//    crc_err        CRC mismatch on the trailing check word
// ============================================================================
module cfg_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 20
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cfg_data_outA,
    output logic              cfg_data_outB,
    output logic              cfg_en,
    output logic              busy,
    output logic              done,
    output logic              crc_err
);

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    localparam int PAIRS = WORD_W / 2;
    localparam int PW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int BW    = $clog2(CHAIN_LEN + 1);

    localparam logic [PW-1:0] LAST_PAIR  = PW'(PAIRS - 1);
    localparam logic [BW-1:0] CHAIN_BITS = BW'(CHAIN_LEN);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state;
    logic [WORD_W-1:0] shreg;      // word being serialised, MSB pair first
    logic [BW-1:0]     bits_left;  // bits still owed to each chain
    logic [PW-1:0]     pair_idx;   // pair of the current word on the outputs
    logic              ready_q;    // registered Moore flag: LOAD or CHECK
    logic              shift_q;    // registered Moore flag: SHIFT
    logic              done_q;
    logic              crc_err_q;

`ifdef CFG_LOADER_CRC_EN
    logic [7:0]        crc;

    // One whole word through the CRC-8 (x^8 + x^2 + x + 1), MSB first.
    function automatic logic [7:0] crc8_word(input logic [7:0]        c,
                                             input logic [WORD_W-1:0] d);
        logic [7:0] r;
        r = c;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            if (r[7] ^ d[i]) begin
                r = {r[6:0], 1'b0} ^ 8'h07;
            end else begin
                r = {r[6:0], 1'b0};
            end
        end
        return r;
    endfunction
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The handshake and shift flags are registered per state and then
    // qualified with en, so dropping en stops the chain and the input
    // side in the very same cycle without disturbing the stored state.
    assign in_ready      = ready_q & en;
    assign cfg_en        = shift_q & en;
    assign cfg_data_outA = shreg[WORD_W-1];
    assign cfg_data_outB = shreg[WORD_W-2];
    assign done          = done_q;
    assign crc_err       = crc_err_q;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            bits_left <= '0;
            pair_idx  <= '0;
            ready_q   <= 1'b0;
            shift_q   <= 1'b0;
            busy      <= 1'b0;
            done_q    <= 1'b0;
            crc_err_q <= 1'b0;
`ifdef CFG_LOADER_CRC_EN
            crc       <= 8'h00;
`endif
        end else if (en) begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_LOAD;
                        bits_left <= CHAIN_BITS;
                        ready_q   <= 1'b1;
                        busy      <= 1'b1;
                        done_q    <= 1'b0;
                        crc_err_q <= 1'b0;
`ifdef CFG_LOADER_CRC_EN
                        crc       <= 8'h00;
`endif
                    end
                end

                ST_LOAD: begin
                    if (in_valid && in_ready) begin
                        shreg    <= in_data;
                        pair_idx <= '0;
                        state    <= ST_SHIFT;
                        ready_q  <= 1'b0;
                        shift_q  <= 1'b1;
`ifdef CFG_LOADER_CRC_EN
                        crc      <= crc8_word(crc, in_data);
`endif
                    end
                end

                ST_SHIFT: begin
                    // The pair on the outputs is taken by the chains at this
                    // edge, so the next pair moves up into the MSBs.
                    shreg     <= shreg << 2;
                    bits_left <= bits_left - BW'(1);
                    pair_idx  <= pair_idx + PW'(1);
                    if (bits_left == BW'(1)) begin
                        // Last chain bit: any unused low pairs of the final
                        // word are simply dropped here.
                        shift_q <= 1'b0;
`ifdef CFG_LOADER_CRC_EN
                        state   <= ST_CHECK;
                        ready_q <= 1'b1;
`else
                        state   <= ST_DONE;
                        busy    <= 1'b0;
                        done_q  <= 1'b1;
`endif
                    end else if (pair_idx == LAST_PAIR) begin
                        state   <= ST_LOAD;
                        shift_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end

`ifdef CFG_LOADER_CRC_EN
                ST_CHECK: begin
                    if (in_valid && in_ready) begin
                        crc_err_q <= (in_data[7:0] != crc);
                        state     <= ST_DONE;
                        ready_q   <= 1'b0;
                        busy      <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
`endif

                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b0;
                    shift_q <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cfg_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cfg_loader
//  Purpose  : Self-checking bench for cfg_loader. A long instance
//             (CHAIN_LEN=20) and a short instance (CHAIN_LEN=6, partial last
//             word) share clock, reset, enable and the input bus; each has
//             its own start. Expected {A,B} pairs are queued when a word is
//             handed over and checked whenever the DUT asserts cfg_en.
//             Honours CFG_LOADER_CRC_EN to exercise the trailing check word.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cfg_loader;

    localparam int WW   = 8;
    localparam int LEN_L = 20;
    localparam int LEN_S = 6;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          en = 1'b1;
    logic          start_l = 1'b0;
    logic          start_s = 1'b0;
    logic [WW-1:0] in_data = '0;
    logic          in_valid = 1'b0;

    logic in_ready_l, a_l, b_l, cfg_en_l, busy_l, done_l, crc_err_l;
    logic in_ready_s, a_s, b_s, cfg_en_s, busy_s, done_s, crc_err_s;

    always #5 clk = ~clk;

    cfg_loader #(.WORD_W(WW), .CHAIN_LEN(LEN_L)) u_dut_l (
        .clk(clk), .nrst(nrst), .en(en), .start(start_l),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_l),
        .cfg_data_outA(a_l), .cfg_data_outB(b_l), .cfg_en(cfg_en_l),
        .busy(busy_l), .done(done_l), .crc_err(crc_err_l)
    );

    cfg_loader #(.WORD_W(WW), .CHAIN_LEN(LEN_S)) u_dut_s (
        .clk(clk), .nrst(nrst), .en(en), .start(start_s),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_s),
        .cfg_data_outA(a_s), .cfg_data_outB(b_s), .cfg_en(cfg_en_s),
        .busy(busy_s), .done(done_s), .crc_err(crc_err_s)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int         vectors = 0;
    int         miscompares = 0;
    logic [1:0] exp_l[$];
    logic [1:0] exp_s[$];
    int         rem_l = 0, rem_s = 0;
    int         shifts_l = 0, shifts_s = 0;
    logic [7:0] crc_l = 8'h00, crc_s = 8'h00;
    logic [7:0] wbuf[0:7];

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            r = (r[7] ^ d[i]) ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction

    function automatic logic rdy(input int sel);
        return (sel != 0) ? in_ready_s : in_ready_l;
    endfunction

    function automatic logic cen(input int sel);
        return (sel != 0) ? cfg_en_s : cfg_en_l;
    endfunction

    // Chain-side monitor: every cfg_en cycle must carry the next queued pair.
    always @(negedge clk) begin
        logic [1:0] e;
        if (cfg_en_l) begin
            shifts_l++;
            vectors++;
            if (exp_l.size() == 0) begin
                miscompares++;
                $display("FAIL chain_l_extra_shift: got cfg_en=1 at shift %0d, required no shift", shifts_l);
            end else begin
                e = exp_l.pop_front();
                if ({a_l, b_l} !== e) begin
                    miscompares++;
                    $display("FAIL chain_l_bits shift %0d: got {A,B}=%b%b, required %b", shifts_l, a_l, b_l, e);
                end
            end
        end
        if (cfg_en_s) begin
            shifts_s++;
            vectors++;
            if (exp_s.size() == 0) begin
                miscompares++;
                $display("FAIL chain_s_extra_shift: got cfg_en=1 at shift %0d, required no shift", shifts_s);
            end else begin
                e = exp_s.pop_front();
                if ({a_s, b_s} !== e) begin
                    miscompares++;
                    $display("FAIL chain_s_bits shift %0d: got {A,B}=%b%b, required %b", shifts_s, a_s, b_s, e);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all start and end #1 after a rising edge)
    // ------------------------------------------------------------------
    task automatic push_word(input int sel, input logic [7:0] w);
        int n, rem;
        logic [1:0] p;
        rem = (sel != 0) ? rem_s : rem_l;
        n   = (rem < WW / 2) ? rem : WW / 2;
        for (int k = 0; k < n; k++) begin
            p = {w[7 - 2 * k], w[6 - 2 * k]};
            if (sel != 0) exp_s.push_back(p);
            else          exp_l.push_back(p);
        end
        if (sel != 0) begin
            rem_s -= n;
            crc_s = crc8(crc_s, w);
        end else begin
            rem_l -= n;
            crc_l = crc8(crc_l, w);
        end
    endtask

    task automatic pulse_start(input int sel);
        if (sel != 0) begin
            rem_s = LEN_S; crc_s = 8'h00; shifts_s = 0; exp_s.delete(); start_s = 1'b1;
        end else begin
            rem_l = LEN_L; crc_l = 8'h00; shifts_l = 0; exp_l.delete(); start_l = 1'b1;
        end
        @(posedge clk); #1;
        start_l = 1'b0;
        start_s = 1'b0;
    endtask

    // Returns #1 after the accepting edge, i.e. in the first SHIFT cycle.
    task automatic send_word(input int sel, input logic [7:0] w, input logic is_crc);
        int cnt;
        cnt = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!rdy(sel) && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (!rdy(sel)) begin
            vectors++;
            miscompares++;
            $display("FAIL handshake_timeout dut%0d word %h: got in_ready=0 for %0d cycles, required 1", sel, w, cnt);
        end else begin
            if (!is_crc) push_word(sel, w);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int sel, input logic exp_err);
        int cnt;
        logic [4:0] st;
        cnt = 0;
        while (!((sel != 0) ? done_s : done_l) && cnt < 300) begin
            @(posedge clk); #1;
            cnt++;
        end
        st = (sel != 0) ? {in_ready_s, cfg_en_s, busy_s, done_s, crc_err_s}
                        : {in_ready_l, cfg_en_l, busy_l, done_l, crc_err_l};
        vectors++;
        if (st !== {4'b0001, exp_err}) begin
            miscompares++;
            $display("FAIL done_status dut%0d: got {rdy,cfg_en,busy,done,crc_err}=%b, required %b", sel, st, {4'b0001, exp_err});
        end
        vectors++;
        if (((sel != 0) ? shifts_s : shifts_l) != ((sel != 0) ? LEN_S : LEN_L)) begin
            miscompares++;
            $display("FAIL shift_count dut%0d: got %0d, required %0d", sel,
                     (sel != 0) ? shifts_s : shifts_l, (sel != 0) ? LEN_S : LEN_L);
        end
        vectors++;
        if (((sel != 0) ? exp_s.size() : exp_l.size()) != 0) begin
            miscompares++;
            $display("FAIL bits_unshifted dut%0d: got %0d pairs left, required 0", sel,
                     (sel != 0) ? exp_s.size() : exp_l.size());
        end
    endtask

    // Drops en for three cycles in the first SHIFT cycle of word w.
    task automatic freeze_check(input logic [7:0] w);
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            vectors++;
            if ({cfg_en_l, in_ready_l, a_l, b_l} !== {2'b00, w[7], w[6]}) begin
                miscompares++;
                $display("FAIL en_freeze cycle %0d: got {cfg_en,rdy,A,B}=%b, required %b",
                         c, {cfg_en_l, in_ready_l, a_l, b_l}, {2'b00, w[7], w[6]});
            end
        end
        en = 1'b1;
    endtask

    task automatic do_load(input int sel, input int n, input int gap,
                           input int freeze_idx, input logic [7:0] crc_flip);
        pulse_start(sel);
        for (int i = 0; i < n; i++) begin
            send_word(sel, wbuf[i], 1'b0);
            if (i == freeze_idx) freeze_check(wbuf[i]);
            if (gap > 0 && i < n - 1) begin
                repeat (gap) begin @(posedge clk); #1; end
                vectors++;
                if ({rdy(sel), cen(sel)} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL stall_gap dut%0d: got {rdy,cfg_en}=%b, required 10", sel, {rdy(sel), cen(sel)});
                end
            end
        end
`ifdef CFG_LOADER_CRC_EN
        send_word(sel, ((sel != 0) ? crc_s : crc_l) ^ crc_flip, 1'b1);
        wait_done(sel, crc_flip != 8'h00);
`else
        wait_done(sel, 1'b0);
`endif
    endtask

    task automatic apply_reset();
        nrst = 1'b0; in_valid = 1'b0; start_l = 1'b0; start_s = 1'b0; en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        nrst = 1'b1;
        exp_l.delete(); exp_s.delete();
        shifts_l = 0; shifts_s = 0;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        @(posedge clk); #1;
        vectors++;
        if ({in_ready_l, a_l, b_l, cfg_en_l, busy_l, done_l, crc_err_l} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_l: got outputs %b, required 0000000", {in_ready_l, a_l, b_l, cfg_en_l, busy_l, done_l, crc_err_l});
        end
        nrst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        vectors++;
        if ({in_ready_s, a_s, b_s, cfg_en_s, busy_s, done_s, crc_err_s} !== 7'b0) begin
            miscompares++;
            $display("FAIL idle_s: got outputs %b, required 0000000", {in_ready_s, a_s, b_s, cfg_en_s, busy_s, done_s, crc_err_s});
        end
    endtask

    task automatic test_idle_no_valid();
        pulse_start(0);
        for (int c = 0; c < 10; c++) begin
            vectors++;
            if ({in_ready_l, cfg_en_l, busy_l} !== 3'b101) begin
                miscompares++;
                $display("FAIL load_wait cycle %0d: got {rdy,cfg_en,busy}=%b, required 101", c, {in_ready_l, cfg_en_l, busy_l});
            end
            @(posedge clk); #1;
        end
        apply_reset();
    endtask

    task automatic test_full_load();
        wbuf[0] = 8'hAA; wbuf[1] = 8'h55; wbuf[2] = 8'hF0; wbuf[3] = 8'h0F; wbuf[4] = 8'hC3;
        do_load(0, 5, 0, -1, 8'h00);
    endtask

    task automatic test_stall();
        wbuf[0] = 8'h3C; wbuf[1] = 8'h96; wbuf[2] = 8'h01; wbuf[3] = 8'hFE; wbuf[4] = 8'h5A;
        do_load(0, 5, 5, -1, 8'h00);
    endtask

    task automatic test_en_freeze();
        wbuf[0] = 8'h69; wbuf[1] = 8'hB4; wbuf[2] = 8'h2D; wbuf[3] = 8'hE1; wbuf[4] = 8'h87;
        do_load(0, 5, 0, 2, 8'h00);
    endtask

    // Partial last word; start is also pulsed during the final SHIFT cycle.
    task automatic test_partial_last();
        pulse_start(1);
        send_word(1, 8'hE4, 1'b0);
        send_word(1, 8'hB7, 1'b0);
        @(posedge clk); #1;
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
`ifdef CFG_LOADER_CRC_EN
        vectors++;
        if ({in_ready_s, busy_s, done_s} !== 3'b110) begin
            miscompares++;
            $display("FAIL check_state: got {rdy,busy,done}=%b, required 110", {in_ready_s, busy_s, done_s});
        end
        send_word(1, crc_s, 1'b1);
`endif
        wait_done(1, 1'b0);
    endtask

    task automatic test_reset_restart();
        pulse_start(0);
        send_word(0, 8'hAA, 1'b0);
        send_word(0, 8'h55, 1'b0);
        send_word(0, 8'hF0, 1'b0);
        @(posedge clk); #1;
        nrst = 1'b0;
        #1;
        vectors++;
        if ({in_ready_l, cfg_en_l, a_l, b_l, busy_l, done_l} !== 6'b0) begin
            miscompares++;
            $display("FAIL async_reset: got {rdy,cfg_en,A,B,busy,done}=%b, required 000000", {in_ready_l, cfg_en_l, a_l, b_l, busy_l, done_l});
        end
        @(posedge clk); #1;
        nrst = 1'b1;
        exp_l.delete();
        shifts_l = 0;
        test_full_load();
    endtask

`ifdef CFG_LOADER_CRC_EN
    task automatic test_crc();
        wbuf[0] = 8'h01; wbuf[1] = 8'h80;
        do_load(1, 2, 0, -1, 8'h00);
        do_load(1, 2, 0, -1, 8'h0F);
    endtask
`endif

    task automatic test_restart_clears();
        pulse_start(1);
        vectors++;
        if ({done_s, busy_s, crc_err_s, in_ready_s} !== 4'b0101) begin
            miscompares++;
            $display("FAIL restart_flags: got {done,busy,crc_err,rdy}=%b, required 0101", {done_s, busy_s, crc_err_s, in_ready_s});
        end
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_idle_no_valid();
        test_full_load();
        test_partial_last();
        test_stall();
        test_en_freeze();
        test_reset_restart();
`ifdef CFG_LOADER_CRC_EN
        test_crc();
`endif
        test_restart_clears();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
